// File: rtl/ace_snoop_chan_buffer.sv
// ACE snoop channel buffer: AC FIFO with in-flight throttle, CR/CD register slices, CD beat/credit tracking.
// Optional protocol checker enabled by defining ACE_SNOOP_BUF_PROTOCOL_CHECK_EN.
module ace_snoop_chan_buffer #(
    parameter int AddrWidth      = 64,
    parameter int DataWidth      = 64,
    parameter int LineWidth      = 512,
    parameter int AcDepth        = 2,
    parameter int MaxOutstanding = 4,
    localparam int CdBeats       = LineWidth / DataWidth,
    localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ac_valid_i,
    output logic                 ac_ready_o,
    input  logic [AddrWidth-1:0] ac_addr_i,
    input  logic [3:0]           ac_snoop_i,
    input  logic [2:0]           ac_prot_i,
    output logic                 ac_valid_o,
    input  logic                 ac_ready_i,
    output logic [AddrWidth-1:0] ac_addr_o,
    output logic [3:0]           ac_snoop_o,
    output logic [2:0]           ac_prot_o,
    input  logic                 cr_valid_i,
    output logic                 cr_ready_o,
    input  logic [4:0]           cr_resp_i,
    output logic                 cr_valid_o,
    input  logic                 cr_ready_i,
    output logic [4:0]           cr_resp_o,
    input  logic                 cd_valid_i,
    output logic                 cd_ready_o,
    input  logic [DataWidth-1:0] cd_data_i,
    input  logic                 cd_last_i,
    output logic                 cd_valid_o,
    input  logic                 cd_ready_i,
    output logic [DataWidth-1:0] cd_data_o,
    output logic                 cd_last_o,
    output logic [CntW-1:0]      outstanding_o,
    output logic                 err_o
);

    localparam int PtrW  = (AcDepth > 1) ? $clog2(AcDepth) : 1;
    localparam int FillW = $clog2(AcDepth + 1);
    localparam int BeatW = (CdBeats > 1) ? $clog2(CdBeats) : 1;
    localparam int AcW   = AddrWidth + 7;

    logic [AcW-1:0]       ac_mem [AcDepth];
    logic [PtrW-1:0]      rd_ptr;
    logic [PtrW-1:0]      wr_ptr;
    logic [FillW-1:0]     fill;
    logic                 ac_full;
    logic                 ac_empty;
    logic                 ac_push;
    logic                 ac_issue;
    logic [CntW-1:0]      inflight;
    logic [CntW-1:0]      credit;
    logic                 cr_full;
    logic                 cr_hs;
    logic                 cd_full;
    logic                 cd_hs;
    logic [BeatW-1:0]     beat;
    logic                 beat_is_last;
    logic                 credit_inc;
    logic                 credit_dec;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(AcDepth - 1)) return '0;
        else return p + PtrW'(1);
    endfunction

    // AC FIFO: registered head, so a push into an empty FIFO shows up next cycle
    assign ac_full    = (fill == FillW'(AcDepth));
    assign ac_empty   = (fill == '0);
    assign ac_ready_o = !ac_full;
    assign ac_valid_o = !ac_empty && (inflight < CntW'(MaxOutstanding));
    assign ac_push    = ac_valid_i && !ac_full;
    assign ac_issue   = ac_valid_o && ac_ready_i;
    assign {ac_prot_o, ac_snoop_o, ac_addr_o} = ac_mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            for (int i = 0; i < AcDepth; i++) ac_mem[i] <= '0;
        end else begin
            if (ac_push) begin
                ac_mem[wr_ptr] <= {ac_prot_i, ac_snoop_i, ac_addr_i};
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (ac_issue) rd_ptr <= ptr_inc(rd_ptr);
            if (ac_push && !ac_issue) fill <= fill + FillW'(1);
            else if (!ac_push && ac_issue) fill <= fill - FillW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) inflight <= '0;
        else if (ac_issue && !cr_hs) inflight <= inflight + CntW'(1);
        else if (!ac_issue && cr_hs) inflight <= inflight - CntW'(1);
    end
    assign outstanding_o = inflight;

    assign cr_ready_o = !cr_full || cr_ready_i;
    assign cr_valid_o = cr_full;
    assign cr_hs      = cr_valid_i && cr_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cr_full   <= 1'b0;
            cr_resp_o <= '0;
        end else if (cr_hs) begin
            cr_full   <= 1'b1;
            cr_resp_o <= cr_resp_i;
        end else if (cr_ready_i) begin
            cr_full   <= 1'b0;
        end
    end

    // One credit per CR that promised data; returned when the line's final beat is taken
    assign beat_is_last = (beat == BeatW'(CdBeats - 1));
    assign cd_ready_o   = (credit != '0) && (!cd_full || cd_ready_i);
    assign cd_valid_o   = cd_full;
    assign cd_hs        = cd_valid_i && cd_ready_o;
    assign credit_inc   = cr_hs && cr_resp_i[0];
    assign credit_dec   = cd_hs && beat_is_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) credit <= '0;
        else if (credit_inc && !credit_dec) credit <= credit + CntW'(1);
        else if (!credit_inc && credit_dec) credit <= credit - CntW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cd_full   <= 1'b0;
            cd_data_o <= '0;
            cd_last_o <= 1'b0;
            beat      <= '0;
        end else begin
            if (cd_hs) begin
                cd_full   <= 1'b1;
                cd_data_o <= cd_data_i;
                cd_last_o <= beat_is_last;
                beat      <= beat_is_last ? '0 : beat + BeatW'(1);
            end else if (cd_ready_i) begin
                cd_full   <= 1'b0;
            end
        end
    end

`ifdef ACE_SNOOP_BUF_PROTOCOL_CHECK_EN
    logic err_q;
    logic err_set;

    assign err_set = (cr_hs && (inflight == '0) && !ac_issue)
                   || (cd_hs && (cd_last_i != beat_is_last))
                   || (cd_valid_i && (credit == '0));

    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end
    assign err_o = err_q;
`else
    // cd_last_i only matters to the checker; beat tracking is purely counter based
    logic unused_cd_last;
    assign unused_cd_last = cd_last_i;
    assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_ace_snoop_chan_buffer.sv
// Self-checking bench for ace_snoop_chan_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_ace_snoop_chan_buffer;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int LW    = 512;
    localparam int ACD   = 2;
    localparam int MAXO  = 4;
    localparam int BEATS = LW / DW;
    localparam int CW    = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          rst_i;
    logic          ac_valid_i, ac_ready_o, ac_valid_o, ac_ready_i;
    logic [AW-1:0] ac_addr_i, ac_addr_o;
    logic [3:0]    ac_snoop_i, ac_snoop_o;
    logic [2:0]    ac_prot_i, ac_prot_o;
    logic          cr_valid_i, cr_ready_o, cr_valid_o, cr_ready_i;
    logic [4:0]    cr_resp_i, cr_resp_o;
    logic          cd_valid_i, cd_ready_o, cd_valid_o, cd_ready_i;
    logic [DW-1:0] cd_data_i, cd_data_o;
    logic          cd_last_i, cd_last_o;
    logic [CW-1:0] outstanding_o;
    logic          err_o;

    always #5 clk = ~clk;

    ace_snoop_chan_buffer #(
        .AddrWidth(AW), .DataWidth(DW), .LineWidth(LW),
        .AcDepth(ACD), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
        .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
        .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .ac_addr_o(ac_addr_o),
        .ac_snoop_o(ac_snoop_o), .ac_prot_o(ac_prot_o),
        .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
        .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
        .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data_i),
        .cd_last_i(cd_last_i),
        .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
        .cd_last_o(cd_last_o),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    typedef struct packed {
        logic [2:0]    prot;
        logic [3:0]    snoop;
        logic [AW-1:0] addr;
    } ac_t;

    // Reference model: snoops waiting in the buffer, responses/beats held in the output stages
    ac_t          ac_q[$];
    logic [4:0]   cr_q[$];
    logic [DW:0]  cd_q[$];
    int           inflight, credit, beat;
    bit           err_m;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ac_q.delete();
        cr_q.delete();
        cd_q.delete();
        inflight = 0;
        credit   = 0;
        beat     = 0;
        err_m    = 1'b0;
    endtask

    task automatic idle_inputs();
        ac_valid_i = 1'b0;
        cr_valid_i = 1'b0;
        cd_valid_i = 1'b0;
        cd_last_i  = 1'b0;
    endtask

    // Compare every output against the model, then advance the model across one clock edge
    task automatic cycle();
        bit   e_acr, e_acv, e_crr, e_cdr;
        bit   ac_pop, ac_push, cr_hs, cd_hs, last_now;
        ac_t  h;
        logic [DW:0] d;
        @(negedge clk);
        e_acr = ac_q.size() < ACD;
        e_acv = (ac_q.size() != 0) && (inflight < MAXO);
        e_crr = (cr_q.size() == 0) || cr_ready_i;
        e_cdr = (credit != 0) && ((cd_q.size() == 0) || cd_ready_i);
        chk("ac_ready", ac_ready_o, e_acr);
        chk("ac_valid", ac_valid_o, e_acv);
        if (e_acv) begin
            h = ac_q[0];
            chk("ac_addr", ac_addr_o, h.addr);
            chk("ac_snoop", ac_snoop_o, h.snoop);
            chk("ac_prot", ac_prot_o, h.prot);
        end
        chk("cr_ready", cr_ready_o, e_crr);
        chk("cr_valid", cr_valid_o, cr_q.size() != 0);
        if (cr_q.size() != 0) chk("cr_resp", cr_resp_o, cr_q[0]);
        chk("cd_ready", cd_ready_o, e_cdr);
        chk("cd_valid", cd_valid_o, cd_q.size() != 0);
        if (cd_q.size() != 0) begin
            d = cd_q[0];
            chk("cd_data", cd_data_o, d[DW-1:0]);
            chk("cd_last", cd_last_o, d[DW]);
        end
        chk("outstanding", outstanding_o, inflight);
        chk("err", err_o, err_m);

        if (rst_i) begin
            model_reset();
        end else begin
            ac_pop   = e_acv && ac_ready_i;
            ac_push  = ac_valid_i && e_acr;
            cr_hs    = cr_valid_i && e_crr;
            cd_hs    = cd_valid_i && e_cdr;
            last_now = (beat == BEATS - 1);
`ifdef ACE_SNOOP_BUF_PROTOCOL_CHECK_EN
            if ((cr_hs && inflight == 0 && !ac_pop) || (cd_hs && (cd_last_i != last_now))
                || (cd_valid_i && credit == 0))
                err_m = 1'b1;
`endif
            if (ac_pop) void'(ac_q.pop_front());
            if (ac_push) ac_q.push_back({ac_prot_i, ac_snoop_i, ac_addr_i});
            inflight += int'(ac_pop) - int'(cr_hs);
            if (cr_q.size() != 0 && cr_ready_i) void'(cr_q.pop_front());
            if (cr_hs) cr_q.push_back(cr_resp_i);
            credit += int'(cr_hs && cr_resp_i[0]) - int'(cd_hs && last_now);
            if (cd_q.size() != 0 && cd_ready_i) void'(cd_q.pop_front());
            if (cd_hs) begin
                cd_q.push_back({last_now, cd_data_i});
                beat = (beat + 1) % BEATS;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        @(negedge clk);
        chk({tag, "_ac_ready"}, ac_ready_o, 1);
        chk({tag, "_ac_valid"}, ac_valid_o, 0);
        chk({tag, "_ac_addr"}, ac_addr_o, 0);
        chk({tag, "_ac_snoop"}, ac_snoop_o, 0);
        chk({tag, "_ac_prot"}, ac_prot_o, 0);
        chk({tag, "_cr_valid"}, cr_valid_o, 0);
        chk({tag, "_cr_ready"}, cr_ready_o, 1);
        chk({tag, "_cr_resp"}, cr_resp_o, 0);
        chk({tag, "_cd_valid"}, cd_valid_o, 0);
        chk({tag, "_cd_ready"}, cd_ready_o, 0);
        chk({tag, "_cd_data"}, cd_data_o, 0);
        chk({tag, "_cd_last"}, cd_last_o, 0);
        chk({tag, "_outstanding"}, outstanding_o, 0);
        chk({tag, "_err"}, err_o, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_ac(input logic [AW-1:0] a, input logic [3:0] s);
        ac_valid_i = 1'b1;
        ac_addr_i  = a;
        ac_snoop_i = s;
        ac_prot_i  = 3'd0;
        cycle();
        ac_valid_i = 1'b0;
    endtask

    task automatic send_cr(input logic [4:0] r);
        cr_valid_i = 1'b1;
        cr_resp_i  = r;
        cycle();
        cr_valid_i = 1'b0;
    endtask

    task automatic send_line(input logic [DW-1:0] base, input int bad_last_beat, input int stop_after);
        for (int b = 0; b < stop_after; b++) begin
            cd_valid_i = 1'b1;
            cd_data_i  = base + DW'(b);
            cd_last_i  = (bad_last_beat >= 0) ? (b == bad_last_beat) : (b == BEATS - 1);
            cycle();
        end
        cd_valid_i = 1'b0;
        cd_last_i  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int  b, guard;
        bit  acc;
        idle_inputs();
        ac_addr_i = '0; ac_snoop_i = '0; ac_prot_i = '0; cr_resp_i = '0; cd_data_i = '0;
        ac_ready_i = 1'b0; cr_ready_i = 1'b1; cd_ready_i = 1'b1;
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
        check_reset("rst");

        // single snoop, dataless response
        send_ac(64'h8000_0040, 4'h1);
        cycle();
        chk("single_ac_valid", ac_valid_o, 1);
        chk("single_ac_addr", ac_addr_o, 64'h8000_0040);
        ac_ready_i = 1'b1;
        cycle();
        ac_ready_i = 1'b0;
        chk("single_outstanding", outstanding_o, 1);
        send_cr(5'h00);
        chk("single_cr_valid", cr_valid_o, 1);
        chk("single_outstanding_0", outstanding_o, 0);
        repeat (2) cycle();

        // throttle at MaxOutstanding, FIFO then fills
        ac_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) send_ac(64'h1000 + AW'(i * 64), 4'h7);
        repeat (3) cycle();
        chk("thr_outstanding", outstanding_o, 4);
        chk("thr_ac_valid", ac_valid_o, 0);
        chk("thr_ac_ready", ac_ready_o, 0);
        send_cr(5'h01);
        repeat (2) cycle();
        chk("thr_release_out", outstanding_o, 4);
        chk("thr_release_ready", ac_ready_o, 1);

        // full line with downstream ready held high
        send_line(64'd0, -1, BEATS);
        repeat (2) cycle();
        chk("line_cd_ready_after", cd_ready_o, 0);

        // backpressure: downstream ready toggles every cycle
        send_cr(5'h01);
        b = 0;
        guard = 0;
        while (b < BEATS && guard < 64) begin
            cd_ready_i = guard[0];
            cd_valid_i = 1'b1;
            cd_data_i  = 64'd100 + DW'(b);
            cd_last_i  = (b == BEATS - 1);
            acc = (credit != 0) && ((cd_q.size() == 0) || cd_ready_i);
            cycle();
            if (acc) b++;
            guard++;
        end
        chk("bp_beats_accepted", b, BEATS);
        cd_valid_i = 1'b0;
        cd_ready_i = 1'b1;
        repeat (2) cycle();

        // early last on beat 3, then long idle
        send_cr(5'h01);
        send_line(64'd200, 3, BEATS);
        repeat (100) cycle();
`ifdef ACE_SNOOP_BUF_PROTOCOL_CHECK_EN
        chk("proto_err_held", err_o, 1);
`else
        chk("proto_err_off", err_o, 0);
`endif
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        check_reset("proto_rst");

        // reset after beat 4, then a fresh line
        ac_ready_i = 1'b1;
        send_ac(64'h2000, 4'h9);
        repeat (2) cycle();
        send_cr(5'h01);
        send_line(64'd300, -1, 5);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        check_reset("mid_rst");
        send_ac(64'h3000, 4'h9);
        repeat (2) cycle();
        send_cr(5'h01);
        send_line(64'd400, -1, BEATS);
        repeat (2) cycle();

        // random traffic, kept protocol-legal from the cache side
        for (int n = 0; n < 1500; n++) begin
            ac_valid_i = ($urandom_range(0, 1) == 1);
            ac_addr_i  = {$urandom, $urandom};
            ac_snoop_i = 4'($urandom);
            ac_prot_i  = 3'($urandom);
            ac_ready_i = ($urandom_range(0, 3) != 0);
            cr_valid_i = (inflight > 0) && ($urandom_range(0, 1) == 1);
            cr_resp_i  = 5'($urandom);
            if (credit >= 3) cr_resp_i[0] = 1'b0;
            cr_ready_i = ($urandom_range(0, 3) != 0);
            cd_valid_i = (credit > 0) && ($urandom_range(0, 3) != 0);
            cd_data_i  = {$urandom, $urandom};
            cd_last_i  = (beat == BEATS - 1);
            cd_ready_i = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ace_snoop_chan_buffer.md
# ace_snoop_chan_buffer

- Parametrised buffer and flow-control stage for the ACE snoop channels (AC, CR, CD), between the interconnect snoop port and the cache snoop controller.
- Decouples the channels with an AC FIFO and CR/CD register slices.
- Limits in-flight snoops at the cache, counts CD beats per cache line, and optionally checks snoop protocol.
- Replaces the fixed-width, unbuffered AC/CR/CD struct connection with width-, depth- and line-size-generic hardware.

## Interface
- AddrWidth, 64, AC address width
- DataWidth, 64, CD data width
- LineWidth, 512, cache-line bits; CdBeats = LineWidth/DataWidth (integer, ≥1)
- AcDepth, 2, AC FIFO entries (≥1)
- MaxOutstanding, 4, max snoops issued to cache without CR; CntW = $clog2(MaxOutstanding+1)
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, synchronous, active-high
- ac_valid_i / ac_ready_o  in/out  1  AC handshake from interconnect
- ac_addr_i  in  AddrWidth; ac_snoop_i  in  4; ac_prot_i  in  3  AC payload
- ac_valid_o / ac_ready_i  out/in  1  AC handshake to cache
- ac_addr_o  out  AddrWidth; ac_snoop_o  out  4; ac_prot_o  out  3  AC payload
- cr_valid_i / cr_ready_o  in/out  1; cr_resp_i  in  5  CR from cache
- cr_valid_o / cr_ready_i  out/in  1; cr_resp_o  out  5  CR to interconnect
- cd_valid_i / cd_ready_o  in/out  1; cd_data_i  in  DataWidth; cd_last_i  in  1  CD from cache
- cd_valid_o / cd_ready_i  out/in  1; cd_data_o  out  DataWidth; cd_last_o  out  1  CD to interconnect
- outstanding_o  out  CntW  snoops issued to cache awaiting CR
- err_o  out  1  sticky protocol error

## Operation
- **AC path:** FIFO of AcDepth entries. ac_ready_o = !full. ac_valid_o = !empty && inflight < MaxOutstanding. Payload is the FIFO head.
- **inflight counter:** +1 on cache-side AC handshake; −1 on cache-side CR handshake; unchanged when both occur in the same cycle. Drives outstanding_o.
- **CR path:** one-entry register slice. cr_ready_o = !slice_full || cr_ready_i. cr_resp_o carries cr_resp_i unchanged.
- **Data credit counter (CntW bits):** +1 when a cache-side CR handshake has cr_resp_i[0] (DataTransfer) = 1. −1 when the cache-side CD beat carrying the final beat is accepted. Simultaneous increment and decrement leaves it unchanged.
- **CD path:** one-entry register slice. cd_ready_o = credit != 0 && (!slice_full || cd_ready_i).
- **Beat counter:** 0..CdBeats-1, advances on each cache-side CD handshake, wraps to 0 after CdBeats-1.
- **cd_last_o:** registered as (beat == CdBeats-1); derived from the counter, not from cd_last_i.
- **CdBeats == 1:** every beat is last.

## Timing
- AC: 1-cycle minimum latency, input handshake to ac_valid_o. No combinational path from input to output.
- CR and CD: 1-cycle latency through their slices. Full throughput of one transfer per cycle when the downstream ready is held high.
- Reset values: ac_ready_o=1, ac_valid_o=0, cr_valid_o=0, cr_ready_o=1, cd_valid_o=0, cd_ready_o=0, outstanding_o=0, err_o=0. All payload outputs are 0.
- Reset mid-operation clears the FIFO, both slices, and all counters in the next cycle. In-flight beats are dropped.
- FIFO full with simultaneous push and pop: ac_ready_o stays 0 and no push occurs.
- FIFO empty: no fall-through; a push into an empty FIFO appears the next cycle.
- inflight == MaxOutstanding: ac_valid_o is held 0 even when the FIFO is non-empty.
- Valid/ready rule on all outputs: once valid is asserted, it and its payload stay stable until ready.

## Configuration
- Macro: ACE_SNOOP_BUF_PROTOCOL_CHECK_EN.
- **Defined:** err_o is set and held until reset on any of the following:
  - cache-side CR handshake while inflight == 0 (and no same-cycle AC issue)
  - cd_last_i differs from (beat == CdBeats-1) on a cache-side CD handshake
  - cd_valid_i asserted while credit == 0
- **Undefined:** err_o is tied to 0 and no check logic is instantiated. All datapath behaviour is identical.

## Test plan
- **Reset then single snoop:** push AC addr 0x8000_0040, snoop 4'h1. Expect ac_valid_o 1 cycle later with identical payload, then outstanding_o=1. Cache CR resp 5'h00 → cr_valid_o one cycle later, resp 5'h00, outstanding_o=0, no CD accepted.
- **Throttle:** MaxOutstanding=4, cache ac_ready_i=1, no CR, 6 ACs pushed. Expect exactly 4 issued and ac_valid_o=0 afterwards. The FIFO then fills (AcDepth=2) and ac_ready_o=0. One CR releases exactly one more AC.
- **Data transfer:** CR resp 5'h01, then 8 CD beats 0..7 (DataWidth=64, LineWidth=512) with cd_ready_i=1. Expect cd_data_o sequence 0..7, cd_last_o only on beat 7, credit back to 0, cd_ready_o=0 after.
- **Backpressure:** cd_ready_i toggled 1/0 every cycle during a line. Expect no beats lost or duplicated, and payload stable while cd_valid_o=1 and ready=0.
- **Protocol check (macro defined):** cd_last_i=1 on beat 3 → err_o=1 next cycle, held through 100 idle cycles, cleared only by rst_i. With the macro undefined, same stimulus → err_o=0.
- **Reset mid-line:** assert rst_i after beat 4. Expect all outputs at reset values next cycle. A new 8-beat transfer afterwards has cd_last_o on its 8th beat.
